// File: rtl/ldpc_iter_scheduler.sv
// Frame sequencer for the LDPC PE array: load, alternating CNU/VNU sweeps with
// syndrome-based early stop, then read-out of the decoded words.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start
// S_LOAD      | accepting L intrinsic words (int_valid stalls)
// S_CNU       | check-node sweep, one address per cycle
// S_CNU_FLUSH | CNU pipeline writeback, CNU_LAT cycles
// S_CHECK     | decide: converged / iteration limit / another VNU pass
// S_VNU       | variable-node sweep, one address per cycle
// S_VNU_FLUSH | VNU pipeline writeback, VNU_LAT cycles
// S_READ      | L read addresses, plus one tail cycle for the last out_valid
// S_DONE      | one-cycle done pulse
module ldpc_iter_scheduler #(
    parameter int L          = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int K          = 6,
    parameter int MAX_ITER   = 8,
    parameter int ITER_WIDTH = 4,
    parameter int CNU_LAT    = 3,
    parameter int VNU_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  int_valid,
    output logic                  int_ready,
    output logic                  en,
    output logic [ADDR_WIDTH-1:0] load_add,
    output logic [ADDR_WIDTH-1:0] proc_add,
    output logic                  cnu_phase,
    output logic                  vnu_phase,
    input  logic                  p_valid,
    input  logic [3*K-1:0]        p_bit,
    output logic [ADDR_WIDTH-1:0] read_add,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic                  converged
);

    localparam int LAT_MAX = (CNU_LAT > VNU_LAT) ? CNU_LAT : VNU_LAT;
    localparam int LAT_W   = $clog2(LAT_MAX + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(L - 1);
    localparam logic [LAT_W-1:0]      CNU_LOAD  = LAT_W'(CNU_LAT - 1);
    localparam logic [LAT_W-1:0]      VNU_LOAD  = LAT_W'(VNU_LAT - 1);
    localparam logic [ITER_WIDTH-1:0] ITER_MAX  = ITER_WIDTH'(MAX_ITER);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CNU, S_CNU_FLUSH, S_CHECK,
        S_VNU, S_VNU_FLUSH, S_READ, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic [ITER_WIDTH-1:0]   iter_q, iter_d;
    logic                    conv_q, conv_d;
    logic                    syn_q, syn_d;
    logic                    tail_q, tail_d;
    logic                    out_valid_q, out_valid_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            lat_q       <= '0;
            iter_q      <= '0;
            conv_q      <= 1'b0;
            syn_q       <= 1'b0;
            tail_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            lat_q       <= lat_d;
            iter_q      <= iter_d;
            conv_q      <= conv_d;
            syn_q       <= syn_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lat_d       = lat_q;
        iter_d      = iter_q;
        conv_d      = conv_q;
        syn_d       = syn_q;
        tail_d      = tail_q;
        out_valid_d = 1'b0;
        int_ready   = 1'b0;
        en          = 1'b0;
        load_add    = '0;
        proc_add    = '0;
        read_add    = '0;
        cnu_phase   = 1'b0;
        vnu_phase   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    iter_d  = '0;
                    conv_d  = 1'b0;
                end
            end
            S_LOAD: begin
                int_ready = 1'b1;
                if (int_valid) begin
                    en       = 1'b1;
                    load_add = addr_q;
                    if (addr_q == ADDR_LAST) begin
                        addr_d  = '0;
                        syn_d   = 1'b0;
                        state_d = S_CNU;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_CNU, S_CNU_FLUSH: begin
                en        = 1'b1;
                cnu_phase = 1'b1;
                proc_add  = addr_q;
                if (p_valid) begin
                    syn_d = syn_q | (|p_bit);
                end
                if (state_q == S_CNU) begin
                    if (addr_q == ADDR_LAST) begin
                        lat_d   = CNU_LOAD;
                        state_d = S_CNU_FLUSH;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end else if (lat_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_CHECK: begin
                addr_d = '0;
                tail_d = 1'b0;
                if (!syn_q) begin
                    conv_d  = 1'b1;
                    state_d = S_READ;
                end else if (iter_q == ITER_MAX) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_VNU;
                end
            end
            S_VNU, S_VNU_FLUSH: begin
                en        = 1'b1;
                vnu_phase = 1'b1;
                proc_add  = addr_q;
                if (state_q == S_VNU) begin
                    if (addr_q == ADDR_LAST) begin
                        lat_d   = VNU_LOAD;
                        state_d = S_VNU_FLUSH;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end else if (lat_q == '0) begin
                    addr_d  = '0;
                    syn_d   = 1'b0;
                    iter_d  = iter_q + ITER_WIDTH'(1);
                    state_d = S_CNU;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_READ: begin
                en       = 1'b1;
                read_add = addr_q;
                // The tail cycle only carries the final out_valid; read_add stays at L-1.
                if (tail_q) begin
                    state_d = S_DONE;
                end else begin
                    out_valid_d = 1'b1;
                    if (addr_q == ADDR_LAST) begin
                        tail_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_valid  = out_valid_q;
    assign iter_count = iter_q;
    assign converged  = conv_q;

endmodule

// File: tb/tb_ldpc_iter_scheduler.sv
// Scoreboard bench for ldpc_iter_scheduler: stimulus queues expected read words
// and end-of-frame results; a monitor pops and compares as outputs appear.
module tb_ldpc_iter_scheduler;

    localparam int L  = 32;
    localparam int AW = 5;
    localparam int K  = 6;
    localparam int MI = 2;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_n, start, int_valid, p_valid;
    logic [3*K-1:0] p_bit;
    logic          int_ready, en, cnu_phase, vnu_phase, out_valid, busy, done, converged;
    logic [AW-1:0] load_add, proc_add, read_add;
    logic [IW-1:0] iter_count;

    always #5 clk = ~clk;

    ldpc_iter_scheduler #(
        .L(L), .ADDR_WIDTH(AW), .K(K), .MAX_ITER(MI), .ITER_WIDTH(IW),
        .CNU_LAT(3), .VNU_LAT(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .int_valid(int_valid),
        .int_ready(int_ready), .en(en), .load_add(load_add), .proc_add(proc_add),
        .cnu_phase(cnu_phase), .vnu_phase(vnu_phase), .p_valid(p_valid), .p_bit(p_bit),
        .read_add(read_add), .out_valid(out_valid), .busy(busy), .done(done),
        .iter_count(iter_count), .converged(converged)
    );

    typedef struct {
        bit is_done;
        int word;
        int iter;
        bit conv;
        int cycles;
        int cnu_w;
        int vnu_w;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   zero_from = 99;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // p_bit is all ones except inside CNU windows numbered >= zero_from; p_valid
    // stays high so accumulation outside CNU/CNU_FLUSH would corrupt the result.
    initial begin : drv
        int pass;
        bit prev;
        pass = 0;
        prev = 1'b0;
        p_valid = 1'b1;
        p_bit = '1;
        forever begin
            @(negedge clk);
            if (!busy) pass = 0;
            else if (cnu_phase && !prev) pass++;
            prev = cnu_phase;
            p_bit = (cnu_phase && pass >= zero_from) ? '0 : '1;
        end
    end

    initial begin : mon
        int cw, vw, ov;
        bit pc, pv;
        logic [AW-1:0] pra;
        exp_t e;
        cw = 0; vw = 0; ov = 0; pc = 1'b0; pv = 1'b0; pra = '0;
        forever begin
            @(negedge clk);
            if (cnu_phase || vnu_phase) chk("phase_exclusive", cnu_phase & vnu_phase, 0);
            if (!busy) begin
                cw = 0; vw = 0; ov = 0;
            end
            if (cnu_phase && !pc) cw++;
            if (vnu_phase && !pv) vw++;
            if (out_valid) begin
                ov++;
                if (sb.size() == 0) fail_now("unexpected_out_valid");
                else begin
                    e = sb.pop_front();
                    chk("ov_entry_kind", e.is_done, 0);
                    chk("read_add_lag", pra, e.word);
                end
            end
            if (done) begin
                if (sb.size() == 0) fail_now("unexpected_done");
                else begin
                    e = sb.pop_front();
                    chk("done_entry_kind", e.is_done, 1);
                    chk("iter_count", iter_count, e.iter);
                    chk("converged", converged, e.conv);
                    chk("frame_cycles", cyc - start_cyc + 1, e.cycles);
                    chk("cnu_windows", cw, e.cnu_w);
                    chk("vnu_windows", vw, e.vnu_w);
                    chk("out_valid_count", ov, L);
                end
            end
            pc = cnu_phase;
            pv = vnu_phase;
            pra = read_add;
        end
    end

    task automatic push_frame(input int it, input bit cv, input int cycles,
                              input int cw, input int vw);
        exp_t e;
        for (int w = 0; w < L; w++) begin
            e = '{is_done: 1'b0, word: w, iter: 0, conv: 1'b0, cycles: 0, cnu_w: 0, vnu_w: 0};
            sb.push_back(e);
        end
        e = '{is_done: 1'b1, word: 0, iter: it, conv: cv, cycles: cycles, cnu_w: cw, vnu_w: vw};
        sb.push_back(e);
    endtask

    task automatic issue_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
    endtask

    task automatic do_load(input bit stall);
        int k;
        bit iv;
        k = 0;
        for (int i = 0; k < L && i < 4 * L; i++) begin
            @(negedge clk);
            start = 1'b0;
            iv = stall ? (i % 2 == 0) : 1'b1;
            int_valid = iv;
            #1;
            chk("load_int_ready", int_ready, 1);
            chk("load_en", en, iv);
            if (iv) begin
                chk("load_add", load_add, k);
                k++;
            end
        end
        @(negedge clk);
        int_valid = 1'b0;
        #1;
        chk("cnu_entry_phase", cnu_phase, 1);
        chk("cnu_entry_proc_add", proc_add, 0);
        chk("cnu_entry_int_ready", int_ready, 0);
    endtask

    task automatic wait_done(input bit start_in_done, input int it, input bit cv);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 2000);
        if (!done) begin
            fail_now("timeout_waiting_done");
            return;
        end
        int_valid = 1'b0;
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_iter_hold", iter_count, it);
        chk("idle_conv_hold", converged, cv);
        @(negedge clk);
        #1 chk("idle_stays_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        start = 1'b0;
        int_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", en, 0);
        chk("rst_int_ready", int_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_conv", converged, 0);
        chk("rst_phases", {cnu_phase, vnu_phase}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Stalled load, converges on the first CHECK: 63 + 36 + 33 + 1.
        zero_from = 1;
        push_frame(0, 1'b1, 133, 1, 0);
        issue_start();
        do_load(1'b1);
        wait_done(1'b0, 0, 1'b1);

        // No convergence: start pulsed in CNU, int_valid high in READ.
        zero_from = 99;
        push_frame(2, 1'b0, 242, 3, 2);
        issue_start();
        do_load(1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("timeout_waiting_out_valid");
        int_valid = 1'b1;
        #1;
        chk("read_int_ready", int_ready, 0);
        chk("read_load_add", load_add, 0);
        chk("read_en", en, 1);
        wait_done(1'b0, 2, 1'b0);

        // Early stop on second CHECK; start offered during DONE must be ignored.
        zero_from = 2;
        push_frame(1, 1'b1, 172, 2, 1);
        issue_start();
        do_load(1'b0);
        wait_done(1'b1, 1, 1'b1);

        // Abort mid-VNU by reset, then a clean frame.
        zero_from = 99;
        issue_start();
        do_load(1'b0);
        n = 0;
        while (!vnu_phase && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!vnu_phase) fail_now("timeout_waiting_vnu");
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_en", en, 0);
        chk("abort_vnu", vnu_phase, 0);
        chk("abort_proc_add", proc_add, 0);
        chk("abort_iter", iter_count, 0);
        chk("abort_conv", converged, 0);
        @(negedge clk);
        reset_n = 1'b1;
        zero_from = 1;
        push_frame(0, 1'b1, 102, 1, 0);
        issue_start();
        do_load(1'b0);
        wait_done(1'b0, 0, 1'b1);

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
